pe_tile_seq_ctrl: RTL and testbench

- Multi-tile GeMV sequencer for one gemv_subarray.
- Computes y = W·x over runtime-configured M row-tiles and K column-tiles, with the K-tile loop handled internally.
- Streams full-width weight and input BRAM reads back-to-back, one beat per cycle, with a parametrised read latency.
- Accumulates each row-tile over K beats and writes one output word per row-tile. Sits between the layer controller and the subarray/buffer trio.

---
 rtl/pe_tile_seq_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_pe_tile_seq_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_tile_seq_ctrl.sv
// pe_tile_seq_ctrl
//   Multi-tile GeMV sequencer for one gemv_subarray. Computes y = W*x over
//   cfg_m_tiles row-tiles, each accumulated over cfg_k_tiles column beats.
//   Weight and input words are read back-to-back (one beat per cycle). A
//   RD_LATENCY-deep beat pipeline lines the gemv enable up with the returning
//   read data. After the last gemv_valid_out of a tile, one output word is written.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   start               start pulse, sampled only while idle
//   cfg_k_tiles/m_tiles K/M tile counts, latched on start
//   busy, done, err     status; err accompanies done for an illegal config
//   wbuf_*              weight buffer read port (addr = m*KT + k)
//   ibuf_*              input buffer read port (addr = k)
//   obuf_*              output buffer write port (addr = m)
//   gemv_*              subarray control and data reinterpretation
module pe_tile_seq_ctrl #(
  parameter int SUBARRAY_ROWS = 32,
  parameter int SUBARRAY_COLS = 8,
  parameter int INPUT_WIDTH   = 8,
  parameter int WEIGHT_WIDTH  = 8,
  parameter int OUTPUT_WIDTH  = 32,
  parameter int BUF_DEPTH     = 64,
  parameter int MAX_KT        = 8,
  parameter int MAX_MT        = 8,
  parameter int RD_LATENCY    = 2
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     start,
  input  logic [$clog2(MAX_KT+1)-1:0]              cfg_k_tiles,
  input  logic [$clog2(MAX_MT+1)-1:0]              cfg_m_tiles,
  output logic                                     busy,
  output logic                                     done,
  output logic                                     err,
  output logic [$clog2(BUF_DEPTH)-1:0]             wbuf_addr,
  output logic                                     wbuf_rd_en,
  input  logic [SUBARRAY_ROWS*SUBARRAY_COLS*WEIGHT_WIDTH-1:0] wbuf_rdata,
  output logic [$clog2(MAX_KT)-1:0]                ibuf_addr,
  output logic                                     ibuf_rd_en,
  input  logic [SUBARRAY_COLS*INPUT_WIDTH-1:0]     ibuf_rdata,
  output logic [$clog2(MAX_MT)-1:0]                obuf_addr,
  output logic                                     obuf_wr_en,
  output logic [SUBARRAY_ROWS*OUTPUT_WIDTH-1:0]    obuf_wdata,
  output logic                                     gemv_enable,
  output logic                                     gemv_clear_acc,
  output logic [SUBARRAY_COLS-1:0][INPUT_WIDTH-1:0] gemv_input_vector,
  output logic [SUBARRAY_ROWS-1:0][SUBARRAY_COLS-1:0][WEIGHT_WIDTH-1:0] gemv_weight_matrix,
  input  logic [SUBARRAY_ROWS-1:0][OUTPUT_WIDTH-1:0] gemv_output_vector,
  input  logic                                     gemv_valid_out
);

  localparam int KTW = $clog2(MAX_KT+1);
  localparam int MTW = $clog2(MAX_MT+1);
  localparam int WA  = $clog2(BUF_DEPTH);
  localparam int IA  = $clog2(MAX_KT);
  localparam int OA  = $clog2(MAX_MT);
  localparam int WAF = KTW + MTW;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_STORE,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [KTW-1:0] kt_q, k_q, vcnt_q;
  logic [MTW-1:0] mt_q, m_q;
  logic           err_q;
  logic [RD_LATENCY-1:0] vld_pipe, fst_pipe;

  logic           cfg_bad;
  logic           issue_last;
  logic           tile_last;
  logic           drain_done;
  logic           vcnt_clr;
  logic [KTW:0]   vsum;

  // Pure rewiring of the BRAM words into the subarray's element layout.
  assign gemv_input_vector  = ibuf_rdata;
  assign gemv_weight_matrix = wbuf_rdata;
  assign obuf_wdata         = gemv_output_vector;

  always_comb begin
    cfg_bad    = (cfg_k_tiles == '0) || (cfg_m_tiles == '0) ||
                 (cfg_k_tiles > KTW'(MAX_KT)) || (cfg_m_tiles > MTW'(MAX_MT));
    issue_last = (k_q == kt_q - KTW'(1));
    tile_last  = (m_q == mt_q - MTW'(1));
    // Include the pulse arriving this cycle so STORE follows the last valid directly.
    vsum       = {1'b0, vcnt_q} + {{KTW{1'b0}}, gemv_valid_out};
    drain_done = (vsum >= {1'b0, kt_q});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d        = state_q;
    busy           = 1'b0;
    done           = 1'b0;
    err            = 1'b0;
    wbuf_rd_en     = 1'b0;
    ibuf_rd_en     = 1'b0;
    wbuf_addr      = '0;
    ibuf_addr      = '0;
    obuf_wr_en     = 1'b0;
    obuf_addr      = '0;
    gemv_enable    = vld_pipe[RD_LATENCY-1];
    gemv_clear_acc = vld_pipe[RD_LATENCY-1] & fst_pipe[RD_LATENCY-1];
    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = cfg_bad ? S_DONE : S_ISSUE;
      end
      S_ISSUE: begin
        busy       = 1'b1;
        wbuf_rd_en = 1'b1;
        ibuf_rd_en = 1'b1;
        wbuf_addr  = WA'(WAF'(m_q) * WAF'(kt_q) + WAF'(k_q));
        ibuf_addr  = IA'(k_q);
        if (issue_last) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (drain_done) state_d = S_STORE;
      end
      S_STORE: begin
        busy       = 1'b1;
        obuf_wr_en = 1'b1;
        obuf_addr  = OA'(m_q);
        state_d    = tile_last ? S_DONE : S_ISSUE;
      end
      S_DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        err     = err_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign vcnt_clr = (state_d == S_ISSUE) && (state_q != S_ISSUE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kt_q   <= '0;
      mt_q   <= '0;
      k_q    <= '0;
      m_q    <= '0;
      vcnt_q <= '0;
      err_q  <= 1'b0;
    end else begin
      if (state_q == S_IDLE && start) begin
        kt_q  <= cfg_k_tiles;
        mt_q  <= cfg_m_tiles;
        k_q   <= '0;
        m_q   <= '0;
        err_q <= cfg_bad;
      end
      if (state_q == S_ISSUE) k_q <= issue_last ? '0 : k_q + KTW'(1);
      if (state_q == S_STORE && !tile_last) m_q <= m_q + MTW'(1);
      if (vcnt_clr) vcnt_q <= '0;
      else if (state_q != S_IDLE && gemv_valid_out) vcnt_q <= vcnt_q + KTW'(1);
    end
  end

  // Beat pipeline: delays each issued read by RD_LATENCY so enable meets the data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      fst_pipe <= '0;
    end else begin
      vld_pipe[0] <= (state_q == S_ISSUE);
      fst_pipe[0] <= (state_q == S_ISSUE) && (k_q == '0);
      for (int unsigned i = 1; i < RD_LATENCY; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        fst_pipe[i] <= fst_pipe[i-1];
      end
    end
  end

endmodule

// File: tb/tb_pe_tile_seq_ctrl.sv
// Testbench for pe_tile_seq_ctrl: four instances with RD_LATENCY 1..4, each
// with its own BRAM and gemv models; results compared to a golden GeMV.
module tb_pe_tile_seq_ctrl;

  localparam int ROWS = 32;
  localparam int COLS = 8;
  localparam int IW   = 8;
  localparam int WW   = 8;
  localparam int OW   = 32;
  localparam int WBW  = ROWS*COLS*WW;
  localparam int IBW  = COLS*IW;
  localparam int OBW  = ROWS*OW;
  localparam int NI   = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [NI-1:0] start_v;
  logic [3:0]    cfg_k, cfg_m;
  logic [NI-1:0] busy_v, done_v, err_v, wrd_v, ird_v, owr_v, en_v, clr_v, vout_v;
  logic [5:0]    waddr_v [NI];
  logic [2:0]    iaddr_v [NI];
  logic [2:0]    oaddr_v [NI];
  logic [WBW-1:0] wrdata_v [NI];
  logic [IBW-1:0] irdata_v [NI];
  logic [OBW-1:0] owdata_v [NI];
  logic [COLS-1:0][IW-1:0]            gx_v [NI];
  logic [ROWS-1:0][COLS-1:0][WW-1:0]  gw_v [NI];
  logic [ROWS-1:0][OW-1:0]            gacc [NI];

  logic [WBW-1:0] wpipe [NI][4];
  logic [IBW-1:0] ipipe [NI][4];
  logic [WBW-1:0] wmem [64];
  logic [IBW-1:0] imem [8];
  logic [OBW-1:0] omem [NI][8];

  int cyc = 0;
  bit clr_req;
  int rd_cnt [NI], en_cnt [NI], clr_cnt [NI], wr_cnt [NI], busy_cnt [NI];
  int done_cnt [NI], err_cnt [NI], bad_clr [NI];
  int first_rd [NI], first_en [NI], start_cyc [NI], done_cyc [NI];
  bit started [NI], prev_en [NI];
  int waddr_log [NI][80];
  int iaddr_log [NI][80];

  int checks = 0;
  int errors = 0;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    pe_tile_seq_ctrl #(.RD_LATENCY(g+1)) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start_v[g]),
      .cfg_k_tiles(cfg_k), .cfg_m_tiles(cfg_m),
      .busy(busy_v[g]), .done(done_v[g]), .err(err_v[g]),
      .wbuf_addr(waddr_v[g]), .wbuf_rd_en(wrd_v[g]), .wbuf_rdata(wrdata_v[g]),
      .ibuf_addr(iaddr_v[g]), .ibuf_rd_en(ird_v[g]), .ibuf_rdata(irdata_v[g]),
      .obuf_addr(oaddr_v[g]), .obuf_wr_en(owr_v[g]), .obuf_wdata(owdata_v[g]),
      .gemv_enable(en_v[g]), .gemv_clear_acc(clr_v[g]),
      .gemv_input_vector(gx_v[g]), .gemv_weight_matrix(gw_v[g]),
      .gemv_output_vector(gacc[g]), .gemv_valid_out(vout_v[g])
    );
    assign wrdata_v[g] = wpipe[g][g];
    assign irdata_v[g] = ipipe[g][g];
  end

  function automatic int dot(input logic [COLS-1:0][WW-1:0] w, input logic [COLS-1:0][IW-1:0] x);
    int s;
    s = 0;
    for (int c = 0; c < COLS; c++) s += int'($signed(w[c])) * int'($signed(x[c]));
    return s;
  endfunction

  // Golden GeMV straight from the memory contents.
  function automatic logic [OBW-1:0] ref_y(input int kt, input int m);
    logic [OBW-1:0] y;
    logic [WBW-1:0] wv;
    logic [IBW-1:0] xv;
    int acc;
    y = '0;
    for (int r = 0; r < ROWS; r++) begin
      acc = 0;
      for (int k = 0; k < kt; k++) begin
        wv = wmem[m*kt + k];
        xv = imem[k];
        for (int c = 0; c < COLS; c++)
          acc += int'($signed(wv[(r*COLS+c)*WW +: WW])) * int'($signed(xv[c*IW +: IW]));
      end
      y[r*OW +: OW] = acc;
    end
    return y;
  endfunction

  // BRAM models, gemv model (latency 1) and activity monitors.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < NI; i++) begin
      wpipe[i][0] <= wmem[waddr_v[i]];
      ipipe[i][0] <= imem[iaddr_v[i]];
      for (int s = 1; s < 4; s++) begin
        wpipe[i][s] <= wpipe[i][s-1];
        ipipe[i][s] <= ipipe[i][s-1];
      end
      if (!rst_n) vout_v[i] <= 1'b0;
      else vout_v[i] <= en_v[i];
      if (rst_n && en_v[i])
        for (int r = 0; r < ROWS; r++)
          gacc[i][r] <= (clr_v[i] ? '0 : gacc[i][r]) + OW'(dot(gw_v[i][r], gx_v[i]));
      if (clr_req) begin
        rd_cnt[i] <= 0; en_cnt[i] <= 0; clr_cnt[i] <= 0; wr_cnt[i] <= 0;
        busy_cnt[i] <= 0; done_cnt[i] <= 0; err_cnt[i] <= 0; bad_clr[i] <= 0;
        first_rd[i] <= 0; first_en[i] <= 0; start_cyc[i] <= 0; done_cyc[i] <= 0;
        started[i] <= 1'b0; prev_en[i] <= 1'b0;
        for (int m = 0; m < 8; m++) omem[i][m] <= '0;
      end else begin
        prev_en[i] <= en_v[i];
        if (start_v[i] && !busy_v[i] && !started[i]) begin
          started[i] <= 1'b1;
          start_cyc[i] <= cyc;
        end
        if (owr_v[i]) begin
          omem[i][oaddr_v[i]] <= owdata_v[i];
          wr_cnt[i] <= wr_cnt[i] + 1;
        end
        if (wrd_v[i]) begin
          if (rd_cnt[i] < 80) begin
            waddr_log[i][rd_cnt[i]] <= int'(waddr_v[i]);
            iaddr_log[i][rd_cnt[i]] <= int'(iaddr_v[i]);
          end
          if (rd_cnt[i] == 0) first_rd[i] <= cyc;
          rd_cnt[i] <= rd_cnt[i] + 1;
        end
        if (en_v[i]) begin
          if (en_cnt[i] == 0) first_en[i] <= cyc;
          en_cnt[i] <= en_cnt[i] + 1;
        end
        if (clr_v[i]) clr_cnt[i] <= clr_cnt[i] + 1;
        // Clear must coincide exactly with the first enable of each enable run.
        if ((clr_v[i] && !(en_v[i] && !prev_en[i])) || (en_v[i] && !prev_en[i] && !clr_v[i]))
          bad_clr[i] <= bad_clr[i] + 1;
        if (busy_v[i]) busy_cnt[i] <= busy_cnt[i] + 1;
        if (done_v[i]) begin
          done_cnt[i] <= done_cnt[i] + 1;
          done_cyc[i] <= cyc;
        end
        if (err_v[i]) err_cnt[i] <= err_cnt[i] + 1;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_word(input string name, input logic [OBW-1:0] act, input logic [OBW-1:0] exp);
    int bad_row;
    checks++;
    if (act !== exp) begin
      errors++;
      bad_row = 0;
      for (int r = ROWS-1; r >= 0; r--) if (act[r*OW +: OW] !== exp[r*OW +: OW]) bad_row = r;
      $display("FAIL %s row %0d: got %h expected %h", name, bad_row,
               act[bad_row*OW +: OW], exp[bad_row*OW +: OW]);
    end
  endtask

  task automatic fill_mem();
    for (int w = 0; w < 64; w++)
      for (int j = 0; j < WBW/32; j++) wmem[w][j*32 +: 32] = $urandom();
    for (int w = 0; w < 8; w++)
      for (int j = 0; j < IBW/32; j++) imem[w][j*32 +: 32] = $urandom();
  endtask

  task automatic clear_stats();
    @(negedge clk); clr_req = 1'b1;
    @(negedge clk); clr_req = 1'b0;
  endtask

  task automatic run_cfg(input int inst, input int kt, input int mt, input bit disturb);
    clear_stats();
    cfg_k = 4'(kt);
    cfg_m = 4'(mt);
    start_v[inst] = 1'b1;
    @(negedge clk);
    start_v[inst] = 1'b0;
    for (int n = 0; n < 1500 && done_cnt[inst] == 0; n++) begin
      if (disturb) begin
        cfg_k = 4'($urandom_range(0, 15));
        cfg_m = 4'($urandom_range(0, 15));
        start_v[inst] = (n % 5 == 2);
      end
      @(negedge clk);
    end
    start_v[inst] = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic check_run(input int inst, input int kt, input int mt, input bit exp_err,
                           input int exp_lat, input string tag);
    int nb;
    int legal;
    legal = exp_err ? 0 : 1;
    chk({tag, "_done_cnt"}, done_cnt[inst], 1);
    chk({tag, "_err"}, err_cnt[inst], exp_err ? 1 : 0);
    chk({tag, "_latency"}, done_cyc[inst] - start_cyc[inst], exp_lat);
    chk({tag, "_busy_cycles"}, busy_cnt[inst], exp_lat);
    chk({tag, "_idle_after"}, int'(busy_v[inst]), 0);
    chk({tag, "_reads"}, rd_cnt[inst], legal*kt*mt);
    chk({tag, "_enables"}, en_cnt[inst], legal*kt*mt);
    chk({tag, "_clears"}, clr_cnt[inst], legal*mt);
    chk({tag, "_writes"}, wr_cnt[inst], legal*mt);
    chk({tag, "_clear_align"}, bad_clr[inst], 0);
    if (legal == 1) begin
      nb = 0;
      for (int m = 0; m < mt; m++)
        for (int k = 0; k < kt; k++) begin
          if (waddr_log[inst][m*kt+k] != m*kt + k) nb++;
          if (iaddr_log[inst][m*kt+k] != k) nb++;
        end
      chk({tag, "_addr_seq_errs"}, nb, 0);
      chk({tag, "_rd_to_en_lag"}, first_en[inst] - first_rd[inst], inst + 1);
      for (int m = 0; m < mt; m++)
        chk_word($sformatf("%s_obuf%0d", tag, m), omem[inst][m], ref_y(kt, m));
    end
  endtask

  typedef struct {
    int kt;
    int mt;
    bit err;
    int lat;
  } vec_t;

  initial begin
    vec_t tbl [8];
    int kt, mt, snap_rd, snap_en, n;

    tbl[0] = '{1, 1, 1'b0, 6};
    tbl[1] = '{4, 2, 1'b0, 17};
    tbl[2] = '{0, 3, 1'b1, 1};
    tbl[3] = '{3, 9, 1'b1, 1};
    tbl[4] = '{9, 1, 1'b1, 1};
    tbl[5] = '{8, 8, 1'b0, 97};
    tbl[6] = '{2, 5, 1'b0, 31};
    tbl[7] = '{0, 0, 1'b1, 1};

    rst_n   = 1'b0;
    start_v = '0;
    cfg_k   = '0;
    cfg_m   = '0;
    clr_req = 1'b0;
    fill_mem();
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy_v), 0);
    chk("rst_done_err", int'({done_v, err_v}), 0);
    chk("rst_rd_en", int'({wrd_v, ird_v}), 0);
    chk("rst_wr_en", int'(owr_v), 0);
    chk("rst_enable_clear", int'({en_v, clr_v}), 0);
    chk("rst_addrs", int'(waddr_v[1]) + int'(iaddr_v[1]) + int'(oaddr_v[1]), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_busy", int'(busy_v), 0);

    for (int t = 0; t < 8; t++) begin
      fill_mem();
      run_cfg(1, tbl[t].kt, tbl[t].mt, 1'b0);
      check_run(1, tbl[t].kt, tbl[t].mt, tbl[t].err, tbl[t].lat, $sformatf("vec%0d", t));
    end

    for (int t = 0; t < 5; t++) begin
      kt = $urandom_range(1, 8);
      mt = $urandom_range(1, 4);
      fill_mem();
      run_cfg(1, kt, mt, 1'b0);
      check_run(1, kt, mt, 1'b0, mt*(kt + 2 + 1 + 1) + 1, $sformatf("rnd%0d", t));
    end

    fill_mem();
    for (int i = 0; i < NI; i++) begin
      run_cfg(i, 3, 2, 1'b0);
      check_run(i, 3, 2, 1'b0, 2*(3 + (i+1) + 1 + 1) + 1, $sformatf("lat%0d", i+1));
    end

    fill_mem();
    run_cfg(1, 4, 2, 1'b1);
    check_run(1, 4, 2, 1'b0, 17, "restart_ignored");

    fill_mem();
    clear_stats();
    cfg_k = 4'd4;
    cfg_m = 4'd3;
    start_v[1] = 1'b1;
    @(negedge clk);
    start_v[1] = 1'b0;
    n = 0;
    while (rd_cnt[1] < 6 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("arst_in_tile1_issue", int'(wrd_v[1]), 1);
    chk("arst_tile0_written", wr_cnt[1], 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", int'(busy_v[1]), 0);
    chk("arst_rd_en", int'({wrd_v[1], ird_v[1]}), 0);
    chk("arst_enable", int'({en_v[1], clr_v[1]}), 0);
    chk("arst_wbuf_addr", int'(waddr_v[1]), 0);
    snap_rd = rd_cnt[1];
    snap_en = en_cnt[1];
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("arst_no_more_writes", wr_cnt[1], 1);
    chk("arst_no_more_reads", rd_cnt[1], snap_rd);
    chk("arst_no_more_enables", en_cnt[1], snap_en);
    chk("arst_no_done", done_cnt[1], 0);
    chk("arst_idle", int'(busy_v[1]), 0);
    run_cfg(1, 4, 3, 1'b0);
    check_run(1, 4, 3, 1'b0, 25, "after_arst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
